reflet_7seg_scanner: RTL and testbench
======================================

# reflet_7seg_scanner

Scan scheduler for the four-digit multiplexed seven-segment display. It owns the digit-multiplexing sequence: a programmable per-digit time slot, a dead-time sub-step between digits to suppress ghosting, a 16-step brightness duty, and tear-free double-buffering of digit data. Content updates are committed only at frame boundaries. It sits between the seven-segment peripheral's registers and the display pins, replacing the free-running one-digit-per-clock scan.

## Interface
- prescale_width, 16, width of the sub-step prescaler and of `period`
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  scan enable; low blanks the display and holds counters at 0
- period  in  prescale_width  sub-step length minus 1 in clk cycles; live, not buffered
- brightness  in  4  number of lit sub-steps per slot (0 = dark, 15 = max); live
- load  in  1  one-cycle strobe capturing `num`, `dots`, `using_colon` into the pending buffer
- num  in  16  four hex digits; digit k is num[4k+3:4k]
- dots  in  4  decimal point per digit, 1 = lit
- using_colon  in  1  colon lit when 1
- pending  out  1  pending buffer holds data not yet committed
- frame_done  out  1  one-cycle pulse at each frame boundary
- segments  out  7  active-low segments {G,F,E,D,C,B,A}
- selection  out  4  one-hot active-high digit select
- dot  out  1  active-low decimal point
- colon  out  1  active-low colon

## Operation
- Counters: `pre` (prescale_width), `sub` (4 bit), `digit` (2 bit).
- `pre` increments each cycle. When pre >= period, `pre` wraps to 0 and `sub` advances. The >= compare makes a mid-slot decrease of `period` take effect without a runaway.
- When `sub` wraps 15->0, `digit` advances; 3->0 is the frame boundary.
- Slot = 16*(period+1) cycles. Frame = 64*(period+1) cycles.
- States:
  - IDLE (enable=0): counters held at 0, display blank.
  - SCAN (enable=1): counters run.
  - IDLE->SCAN on the first cycle enable is high, starting at digit 0, sub 0, pre 0.
  - SCAN->IDLE on the first cycle enable is low, with counters cleared.
- Lit condition: SCAN and 1 <= sub <= brightness. Sub-step 0 is always dead time.
- While lit:
  - selection = one-hot(digit)
  - segments = active-low hex decode of active digit nibble, using the existing reflet_number_to_segment table
  - dot = !active_dots[digit]
- While not lit: selection=0000, segments=7'h7F, dot=1.
- colon = !active_colon in SCAN, 1 in IDLE. It is not gated by brightness or dead time.
- Buffering:
  - `load` copies the inputs into the pending buffer and sets `pending`.
  - A second `load` before commit overwrites the buffer; the last load wins.
  - Commit copies pending to active and clears `pending`. It happens on the last cycle of digit 3 (pre>=period, sub=15, digit=3), coincident with `frame_done`.
  - In IDLE, commit happens on the cycle after `load`.
- Simultaneous `load` and commit cycle: the new data is committed (bypass) and `pending` stays 0.
- brightness and period changes apply immediately, mid-slot.

## Timing
- Counters, active/pending buffers, and all outputs are registers. Display outputs at cycle t+1 reflect counter/active state at cycle t.
- frame_done is high for exactly one cycle, the cycle after the boundary state. No pulse is generated in IDLE.
- Reset values:
  - segments=7'h7F, selection=0000, dot=1, colon=1
  - frame_done=0, pending=0
  - active and pending buffers all zero
  - counters 0
- Reset mid-frame: all of the above on the next cycle. Pending data is discarded.
- enable low mid-frame: outputs blank on the next cycle. Uncommitted pending data commits on the cycle after enable falls.

## Test plan
- Reset, then enable=0 -> segments=7F, selection=0, dot=colon=1, pending=0, frame_done=0 held for 100 cycles.
- period=0, brightness=15, load num=16'h3210, dots=0001, enable=1 ->
  - each slot: 1 cycle selection=0000, then 15 cycles one-hot lit
  - digit0 segments=7'b1000000 with dot=0; digit3 segments=7'b0110000
  - frame_done every 64 cycles
- period=2, brightness=4 -> slot 48 cycles: 3 dead cycles, 12 lit, 33 dark. brightness=0 -> selection stays 0000; colon still follows using_colon.
- Mid-frame load 16'hABCD, then load 16'h5555 in the same frame ->
  - display unchanged and pending=1 until the boundary
  - from the next frame digits show 5, frame_done seen, pending=0
- load on the exact commit cycle -> data shown the next frame, pending never asserted.
- Drop enable at digit 2 with pending set -> blank the next cycle, pending clears the following cycle. Re-enable -> scan restarts at digit 0, sub 0. Reset mid-frame -> all reset values, buffers zero.

Source files
------------

// File: rtl/reflet_7seg_scanner.sv
`timescale 1ns/1ps
// Purpose: digit-multiplexing scan scheduler for a 4-digit seven-segment display.
// Latency: display outputs are registered, one cycle behind counter/active-buffer state.
// Backpressure: none; load is always accepted, content commits only at frame boundaries.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   enable          scan enable; low blanks the display and clears the counters
//   period          sub-step length minus 1 in clk cycles (live)
//   brightness      lit sub-steps per digit slot, 0..15 (live)
//   load            strobe capturing num/dots/using_colon into the pending buffer
//   num, dots, using_colon  display content (digit k = num[4k+3:4k])
//   pending         pending buffer holds uncommitted data
//   frame_done      one-cycle pulse after each frame boundary
//   segments        active-low {G,F,E,D,C,B,A}
//   selection       one-hot active-high digit select
//   dot, colon      active-low decimal point and colon
module reflet_7seg_scanner #(
  parameter int prescale_width = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [prescale_width-1:0] period,
  input  logic [3:0]                brightness,
  input  logic                      load,
  input  logic [15:0]               num,
  input  logic [3:0]                dots,
  input  logic                      using_colon,
  output logic                      pending,
  output logic                      frame_done,
  output logic [6:0]                segments,
  output logic [3:0]                selection,
  output logic                      dot,
  output logic                      colon
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                    state;
  logic [prescale_width-1:0] pre;
  logic [3:0]                sub;
  logic [1:0]                digit;

  logic [15:0] active_num;
  logic [3:0]  active_dots;
  logic        active_colon;
  logic [15:0] pend_num;
  logic [3:0]  pend_dots;
  logic        pend_colon;

  logic       sub_end;
  logic       frame_end;
  logic       commit;
  logic       lit;
  logic [3:0] nibble;

  // Active-low hex decode, {G,F,E,D,C,B,A}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    case (n)
      4'h0:    hex_to_seg = 7'b1000000;
      4'h1:    hex_to_seg = 7'b1111001;
      4'h2:    hex_to_seg = 7'b0100100;
      4'h3:    hex_to_seg = 7'b0110000;
      4'h4:    hex_to_seg = 7'b0011001;
      4'h5:    hex_to_seg = 7'b0010010;
      4'h6:    hex_to_seg = 7'b0000010;
      4'h7:    hex_to_seg = 7'b1111000;
      4'h8:    hex_to_seg = 7'b0000000;
      4'h9:    hex_to_seg = 7'b0010000;
      4'hA:    hex_to_seg = 7'b0001000;
      4'hB:    hex_to_seg = 7'b0000011;
      4'hC:    hex_to_seg = 7'b1000110;
      4'hD:    hex_to_seg = 7'b0100001;
      4'hE:    hex_to_seg = 7'b0000110;
      default: hex_to_seg = 7'b0001110;
    endcase
  endfunction

  // >= rather than == so that shrinking period mid-slot wraps at once
  // instead of running pre all the way round.
  assign sub_end   = (pre >= period);
  assign frame_end = enable && sub_end && (sub == 4'hF) && (digit == 2'd3);
  // In IDLE there is no frame to tear, so pending data goes straight through.
  // state lags enable by one cycle, which delays that commit by one cycle
  // after enable falls.
  assign commit    = frame_end || ((state == IDLE) && pending);
  // Sub-step 0 is always dark: dead time between digits against ghosting.
  assign lit       = enable && (sub != 4'd0) && (sub <= brightness);
  assign nibble    = active_num[{digit, 2'b00} +: 4];

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pre          <= '0;
      sub          <= '0;
      digit        <= '0;
      active_num   <= '0;
      active_dots  <= '0;
      active_colon <= 1'b0;
      pend_num     <= '0;
      pend_dots    <= '0;
      pend_colon   <= 1'b0;
      pending      <= 1'b0;
      frame_done   <= 1'b0;
      segments     <= 7'h7F;
      selection    <= 4'b0000;
      dot          <= 1'b1;
      colon        <= 1'b1;
    end else begin
      state <= enable ? SCAN : IDLE;

      if (!enable) begin
        pre   <= '0;
        sub   <= '0;
        digit <= '0;
      end else if (sub_end) begin
        pre <= '0;
        sub <= sub + 4'd1;
        if (sub == 4'hF) begin
          digit <= digit + 2'd1;
        end
      end else begin
        pre <= pre + 1'b1;
      end

      // A load landing on the commit cycle bypasses the pending buffer.
      if (load && commit) begin
        active_num   <= num;
        active_dots  <= dots;
        active_colon <= using_colon;
        pending      <= 1'b0;
      end else if (load) begin
        pend_num   <= num;
        pend_dots  <= dots;
        pend_colon <= using_colon;
        pending    <= 1'b1;
      end else if (commit) begin
        active_num   <= pend_num;
        active_dots  <= pend_dots;
        active_colon <= pend_colon;
        pending      <= 1'b0;
      end

      frame_done <= frame_end;

      if (lit) begin
        selection <= 4'b0001 << digit;
        segments  <= hex_to_seg(nibble);
        dot       <= !active_dots[digit];
      end else begin
        selection <= 4'b0000;
        segments  <= 7'h7F;
        dot       <= 1'b1;
      end

      // Colon ignores brightness and dead time.
      colon <= enable ? !active_colon : 1'b1;
    end
  end

endmodule

// File: tb/tb_reflet_7seg_scanner.sv
`timescale 1ns/1ps
// Purpose: directed self-checking bench for reflet_7seg_scanner.
// Latency: samples 1 ns after each rising edge; sample k after enable shows cycle k-1 state.
// Backpressure: none.
module tb_reflet_7seg_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] period;
  logic [3:0]  brightness;
  logic        load;
  logic [15:0] num;
  logic [3:0]  dots;
  logic        using_colon;
  logic        pending;
  logic        frame_done;
  logic [6:0]  segments;
  logic [3:0]  selection;
  logic        dot;
  logic        colon;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_F = 7'b0001110;

  // {segments, selection, dot, colon, pending, frame_done} when blank/reset.
  localparam logic [14:0] BLANK_VEC = {7'h7F, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0};

  logic [6:0] seg_of_digit [4];

  int n_checks = 0;
  int n_fail   = 0;
  int k        = 0;

  always #5 clk = ~clk;

  reflet_7seg_scanner #(.prescale_width(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .period      (period),
    .brightness  (brightness),
    .load        (load),
    .num         (num),
    .dots        (dots),
    .using_colon (using_colon),
    .pending     (pending),
    .frame_done  (frame_done),
    .segments    (segments),
    .selection   (selection),
    .dot         (dot),
    .colon       (colon)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (k=%0d): got %0h expected %0h", tag, k, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  function automatic logic [31:0] out_vec();
    return 32'({segments, selection, dot, colon, pending, frame_done});
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int j;
    int d;
    int s;
    int exp_sel;

    seg_of_digit[0] = SEG_0;
    seg_of_digit[1] = SEG_1;
    seg_of_digit[2] = SEG_2;
    seg_of_digit[3] = SEG_3;

    reset = 1'b1; enable = 1'b0; period = 16'd0; brightness = 4'd15;
    load = 1'b0; num = 16'h0; dots = 4'h0; using_colon = 1'b0;
    repeat (3) step();
    chk_eq("reset_outputs", out_vec(), 32'(BLANK_VEC));
    reset = 1'b0;

    // Idle with enable low: blank for 100 cycles.
    for (int i = 0; i < 100; i++) begin
      step();
      chk_eq("idle_blank", out_vec(), 32'(BLANK_VEC));
    end

    // Load in IDLE: pending for one cycle, then committed.
    num = 16'h3210; dots = 4'b0001; using_colon = 1'b1; load = 1'b1;
    step();
    load = 1'b0;
    chk_eq("idle_load_pending", 32'(pending), 1);
    step();
    chk_eq("idle_commit_clears", 32'(pending), 0);

    // period=0, brightness=15: 1 dead + 15 lit per 16-cycle slot.
    enable = 1'b1; k = 0;
    for (int i = 0; i < 128; i++) begin
      step();
      j = k - 1; d = (j / 16) % 4; s = j % 16;
      exp_sel = (s == 0) ? 0 : (1 << d);
      chk_eq("p0_selection", 32'(selection), 32'(exp_sel));
      chk_eq("p0_segments", 32'(segments), (s == 0) ? 32'h7F : 32'(seg_of_digit[d]));
      chk_eq("p0_dot", 32'(dot), (s != 0 && d == 0) ? 0 : 1);
      chk_eq("p0_frame_done", 32'(frame_done), (j % 64 == 63) ? 1 : 0);
      chk_eq("p0_colon", 32'(colon), 0);
    end

    // period=2, brightness=4: 48-cycle slot, 3 dead, 12 lit, 33 dark.
    enable = 1'b0;
    step(); step();
    chk_eq("disable_blank_sel", 32'(selection), 0);
    period = 16'd2; brightness = 4'd4; enable = 1'b1; k = 0;
    for (int i = 0; i < 192; i++) begin
      step();
      j = k - 1; d = (j / 48) % 4; s = (j / 3) % 16;
      exp_sel = (s >= 1 && s <= 4) ? (1 << d) : 0;
      chk_eq("p2_selection", 32'(selection), 32'(exp_sel));
      chk_eq("p2_frame_done", 32'(frame_done), (j == 191) ? 1 : 0);
    end

    // brightness=0: dark, colon still driven.
    brightness = 4'd0;
    for (int i = 0; i < 48; i++) begin
      step();
      chk_eq("b0_selection", 32'(selection), 0);
      chk_eq("b0_colon", 32'(colon), 0);
    end

    // Double load mid-frame: last wins, committed at the boundary.
    enable = 1'b0;
    step(); step();
    period = 16'd0; brightness = 4'd15; enable = 1'b1; k = 0;
    while (k < 10) step();
    num = 16'hABCD; dots = 4'b0000; using_colon = 1'b0; load = 1'b1;
    step();
    load = 1'b0;
    chk_eq("load1_pending", 32'(pending), 1);
    while (k < 15) step();
    num = 16'h5555; load = 1'b1;
    step();
    load = 1'b0;
    chk_eq("load2_pending", 32'(pending), 1);
    while (k < 20) step();
    chk_eq("old_data_seg", 32'(segments), 32'(SEG_1));
    chk_eq("old_data_sel", 32'(selection), 32'b0010);
    while (k < 63) step();
    chk_eq("pre_boundary_pending", 32'(pending), 1);
    chk_eq("pre_boundary_fd", 32'(frame_done), 0);
    step();
    chk_eq("boundary_pending", 32'(pending), 0);
    chk_eq("boundary_fd", 32'(frame_done), 1);
    chk_eq("boundary_old_seg", 32'(segments), 32'(SEG_3));
    while (k < 66) step();
    chk_eq("new_frame_seg", 32'(segments), 32'(SEG_5));
    chk_eq("new_frame_dot", 32'(dot), 1);
    chk_eq("new_frame_colon", 32'(colon), 1);

    // Load on the exact commit cycle: bypass, pending never set.
    while (k < 127) step();
    chk_eq("before_bypass_seg", 32'(segments), 32'(SEG_5));
    num = 16'h0F0F; dots = 4'b0000; using_colon = 1'b0; load = 1'b1;
    step();
    load = 1'b0;
    chk_eq("bypass_pending", 32'(pending), 0);
    chk_eq("bypass_fd", 32'(frame_done), 1);
    step();
    chk_eq("bypass_pending2", 32'(pending), 0);
    step();
    chk_eq("bypass_seg", 32'(segments), 32'(SEG_F));
    chk_eq("bypass_sel", 32'(selection), 32'b0001);

    // Drop enable in digit 2 with pending data.
    while (k < 150) step();
    num = 16'h1234; dots = 4'hF; using_colon = 1'b1; load = 1'b1;
    step();
    load = 1'b0;
    chk_eq("drop_pending_set", 32'(pending), 1);
    while (k < 165) step();
    chk_eq("digit2_seg", 32'(segments), 32'(SEG_F));
    chk_eq("digit2_sel", 32'(selection), 32'b0100);
    enable = 1'b0;
    step();
    chk_eq("drop_blank", 32'({segments, selection, dot, colon, frame_done}),
           32'({7'h7F, 4'b0000, 1'b1, 1'b1, 1'b0}));
    chk_eq("drop_pending_held", 32'(pending), 1);
    step();
    chk_eq("drop_pending_clear", 32'(pending), 0);

    // Re-enable: restart from digit 0, sub 0 with the committed data.
    enable = 1'b1; k = 0;
    step();
    chk_eq("restart_dead_sel", 32'(selection), 0);
    chk_eq("restart_colon", 32'(colon), 0);
    step();
    chk_eq("restart_d0_seg", 32'(segments), 32'(SEG_4));
    chk_eq("restart_d0_sel", 32'(selection), 32'b0001);
    chk_eq("restart_d0_dot", 32'(dot), 0);
    while (k < 17) step();
    chk_eq("restart_d1_dead", 32'(selection), 0);
    step();
    chk_eq("restart_d1_seg", 32'(segments), 32'(SEG_3));
    chk_eq("restart_d1_sel", 32'(selection), 32'b0010);

    // Reset mid-frame with pending data: everything back to reset values.
    while (k < 30) step();
    num = 16'h9999; dots = 4'hF; using_colon = 1'b1; load = 1'b1;
    step();
    load = 1'b0;
    chk_eq("prereset_pending", 32'(pending), 1);
    reset = 1'b1;
    step();
    chk_eq("midreset_outputs", out_vec(), 32'(BLANK_VEC));
    reset = 1'b0; enable = 1'b0;
    step(); step();
    chk_eq("postreset_pending", 32'(pending), 0);
    enable = 1'b1; k = 0;
    step(); step();
    chk_eq("postreset_seg", 32'(segments), 32'(SEG_0));
    chk_eq("postreset_sel", 32'(selection), 32'b0001);
    chk_eq("postreset_dot", 32'(dot), 1);
    chk_eq("postreset_colon", 32'(colon), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
